// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore-style sequencer for the multicycle datapath: fetch, decode, execute,
// memory and write-back. It generates the IR capture pulse, PC load/select,
// ALU operand/operation selects, memory requests (held until memReady) and
// register-file write controls.
//
// Optional feature macro: ILLEGAL_OP_TRAP_EN
//   defined   : an illegal opcode/mode in EXEC enters HALT (sticky until
//               rst_n), where trap=1 and every other output is 0.
//   undefined : an illegal instruction retires as a NOP (EXEC -> FETCH with no
//               writes); trap is tied 0 and HALT is never entered.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   opcode     in   IR opcode field (OPW bits), sampled in DECODE
//   modeBits   in   IR mode field, sampled in DECODE
//   aluZero    in   ALU result == 0 (branch resolution in EXEC)
//   aluNeg     in   ALU result negative (branch resolution in EXEC)
//   memReady   in   memory access completes this cycle (FETCH/MEM only)
//   IRWrite    out  one-cycle IR capture pulse
//   PCWrite    out  PC load enable
//   PCSrc      out  00 PC+4, 01 PC+signext(imm), 10 jump target
//   ALUSrc     out  0 register operand, 1 extended immediate
//   ALUOp      out  000 AND, 001 ADD, 010 SUB (ALUW bits)
//   extSel     out  1 sign-extend immediate, 0 zero-extend
//   memRead    out  memory read request
//   memWrite   out  memory write request
//   memToReg   out  write-back data from memory
//   regWrite   out  register-file write enable
//   regDst     out  0 write Rd, 1 write Rs1 (post-increment base)
//   stateOut   out  current state encoding
//   trap       out  illegal-instruction trap
//
// State table
//   state  | meaning
//   FETCH  | request instruction word; on memReady capture IR and PC+4
//   DECODE | latch opcode and mode fields
//   EXEC   | ALU op, address generation, branch resolution or jump
//   MEM    | hold LW/SW request until memReady
//   WB     | register write (ALU result or load data)
//   WBINC  | post-increment base register write (Rs1 + imm)
//   HALT   | illegal instruction trapped; sticky until reset
//
// Outputs are decoded combinationally from the state register and the latched
// opcode/mode. The only same-cycle input dependencies are the memReady gating
// in FETCH and the branch-flag resolution in EXEC, both of which must act in
// the cycle they are observed. All outputs are forced low while rst_n is low
// so an in-flight memory request drops immediately on reset.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int OPW  = 6,
    parameter int ALUW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  opcode,
    input  logic [1:0]      modeBits,
    input  logic            aluZero,
    input  logic            aluNeg,
    input  logic            memReady,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic [1:0]      PCSrc,
    output logic            ALUSrc,
    output logic [ALUW-1:0] ALUOp,
    output logic            extSel,
    output logic            memRead,
    output logic            memWrite,
    output logic            memToReg,
    output logic            regWrite,
    output logic            regDst,
    output logic [2:0]      stateOut,
    output logic            trap
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_WBINC  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [OPW-1:0] OP_ANDI = OPW'(0);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(2);
    localparam logic [OPW-1:0] OP_LW   = OPW'(3);
    localparam logic [OPW-1:0] OP_SW   = OPW'(4);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6);
    localparam logic [OPW-1:0] OP_BGT  = OPW'(7);
    localparam logic [OPW-1:0] OP_BLT  = OPW'(8);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(9);

    localparam logic [ALUW-1:0] ALU_AND = ALUW'(0);
    localparam logic [ALUW-1:0] ALU_ADD = ALUW'(1);
    localparam logic [ALUW-1:0] ALU_SUB = ALUW'(2);

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] MODE_PLAIN   = 2'b00;
    localparam logic [1:0] MODE_POSTINC = 2'b01;

    // Bundled control word so the reset gating is applied in one place.
    typedef struct packed {
        logic            ir_write;
        logic            pc_write;
        logic [1:0]      pc_src;
        logic            alu_src;
        logic [ALUW-1:0] alu_op;
        logic            ext_sel;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            reg_write;
        logic            reg_dst;
        logic            trap;
    } ctrl_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] op_lat_q, op_lat_d;
    logic [1:0]     mode_lat_q, mode_lat_d;

    ctrl_t          ctrl_c;
    ctrl_t          ctrl_o;

    // ---------------------------------------------------------------------
    // Instruction classification from the latched fields
    // ---------------------------------------------------------------------
    logic is_andi, is_addi, is_subi, is_lw, is_sw, is_mem;
    logic is_beq, is_bne, is_bgt, is_blt, is_branch, is_jmp, is_alu;
    logic mode_ok, post_inc, legal, branch_taken;
    logic [ALUW-1:0] alu_imm_op;

    always_comb begin
        is_andi   = (op_lat_q == OP_ANDI);
        is_addi   = (op_lat_q == OP_ADDI);
        is_subi   = (op_lat_q == OP_SUBI);
        is_lw     = (op_lat_q == OP_LW);
        is_sw     = (op_lat_q == OP_SW);
        is_beq    = (op_lat_q == OP_BEQ);
        is_bne    = (op_lat_q == OP_BNE);
        is_bgt    = (op_lat_q == OP_BGT);
        is_blt    = (op_lat_q == OP_BLT);
        is_jmp    = (op_lat_q == OP_JMP);
        is_alu    = is_andi | is_addi | is_subi;
        is_mem    = is_lw | is_sw;
        is_branch = is_beq | is_bne | is_bgt | is_blt;

        // Only plain and post-increment addressing exist; mode 1x is reserved.
        mode_ok   = (mode_lat_q == MODE_PLAIN) || (mode_lat_q == MODE_POSTINC);
        post_inc  = (mode_lat_q == MODE_POSTINC);
        legal     = is_alu | is_branch | is_jmp | (is_mem & mode_ok);

        branch_taken = (is_beq &  aluZero)
                     | (is_bne & ~aluZero)
                     | (is_bgt & ~aluNeg & ~aluZero)
                     | (is_blt &  aluNeg);

        alu_imm_op = ALU_AND;
        if (is_addi) begin
            alu_imm_op = ALU_ADD;
        end else if (is_subi) begin
            alu_imm_op = ALU_SUB;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and field latches
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        op_lat_d   = op_lat_q;
        mode_lat_d = mode_lat_q;

        case (state_q)
            S_FETCH: begin
                if (memReady) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                op_lat_d   = opcode;
                mode_lat_d = modeBits;
                state_d    = S_EXEC;
            end

            S_EXEC: begin
                if (!legal) begin
`ifdef ILLEGAL_OP_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
`endif
                end else if (is_alu) begin
                    state_d = S_WB;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_MEM: begin
                if (memReady) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else if (post_inc) begin
                        state_d = S_WBINC;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_WB: begin
                state_d = (is_lw && post_inc) ? S_WBINC : S_FETCH;
            end

            S_WBINC: begin
                state_d = S_FETCH;
            end

            S_HALT: begin
`ifdef ILLEGAL_OP_TRAP_EN
                state_d = S_HALT;
`else
                state_d = S_FETCH;
`endif
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            op_lat_q   <= '0;
            mode_lat_q <= '0;
        end else begin
            state_q    <= state_d;
            op_lat_q   <= op_lat_d;
            mode_lat_q <= mode_lat_d;
        end
    end

    // ---------------------------------------------------------------------
    // Output decode
    // ---------------------------------------------------------------------
    always_comb begin
        ctrl_c = '0;

        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_read = 1'b1;
                // IR capture and PC+4 happen on the cycle the word arrives.
                if (memReady) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    ctrl_c.pc_src   = PC_PLUS4;
                end
            end

            S_DECODE: begin
                ctrl_c = '0;
            end

            S_EXEC: begin
                // An illegal instruction leaves every control low (NOP or trap entry).
                if (legal) begin
                    ctrl_c.ext_sel = ~is_andi;
                    if (is_alu) begin
                        ctrl_c.alu_src = 1'b1;
                        ctrl_c.alu_op  = alu_imm_op;
                    end else if (is_mem) begin
                        ctrl_c.alu_src = 1'b1;
                        ctrl_c.alu_op  = ALU_ADD;
                    end else if (is_branch) begin
                        ctrl_c.alu_src = 1'b0;
                        ctrl_c.alu_op  = ALU_SUB;
                        if (branch_taken) begin
                            ctrl_c.pc_write = 1'b1;
                            ctrl_c.pc_src   = PC_BRANCH;
                        end
                    end else if (is_jmp) begin
                        ctrl_c.pc_write = 1'b1;
                        ctrl_c.pc_src   = PC_JUMP;
                    end
                end
            end

            S_MEM: begin
                // Address generation stays selected while the request is held.
                ctrl_c.ext_sel   = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.mem_read  = is_lw;
                ctrl_c.mem_write = is_sw;
            end

            S_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.reg_dst    = 1'b0;
                ctrl_c.mem_to_reg = is_lw;
                ctrl_c.ext_sel    = ~is_andi;
                ctrl_c.alu_src    = 1'b1;
                ctrl_c.alu_op     = is_lw ? ALU_ADD : alu_imm_op;
            end

            S_WBINC: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
                ctrl_c.ext_sel   = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.alu_op    = ALU_ADD;
            end

            S_HALT: begin
`ifdef ILLEGAL_OP_TRAP_EN
                ctrl_c.trap = 1'b1;
`else
                ctrl_c.trap = 1'b0;
`endif
            end

            default: begin
                ctrl_c = '0;
            end
        endcase
    end

    // Reset forces every control low asynchronously, including requests.
    assign ctrl_o   = rst_n ? ctrl_c : '0;

    assign IRWrite  = ctrl_o.ir_write;
    assign PCWrite  = ctrl_o.pc_write;
    assign PCSrc    = ctrl_o.pc_src;
    assign ALUSrc   = ctrl_o.alu_src;
    assign ALUOp    = ctrl_o.alu_op;
    assign extSel   = ctrl_o.ext_sel;
    assign memRead  = ctrl_o.mem_read;
    assign memWrite = ctrl_o.mem_write;
    assign memToReg = ctrl_o.mem_to_reg;
    assign regWrite = ctrl_o.reg_write;
    assign regDst   = ctrl_o.reg_dst;
`ifdef ILLEGAL_OP_TRAP_EN
    assign trap     = ctrl_o.trap;
`else
    assign trap     = 1'b0;
`endif
    assign stateOut = rst_n ? state_q : 3'd0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [1:0] modeBits;
    logic       aluZero, aluNeg, memReady;
    logic       IRWrite, PCWrite, ALUSrc, extSel, memRead, memWrite;
    logic       memToReg, regWrite, regDst, trap;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic [2:0] stateOut;

    always #5 clk = ~clk;

    multicycle_control_unit #(.OPW(6), .ALUW(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .modeBits(modeBits),
        .aluZero(aluZero), .aluNeg(aluNeg), .memReady(memReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrc(ALUSrc),
        .ALUOp(ALUOp), .extSel(extSel), .memRead(memRead), .memWrite(memWrite),
        .memToReg(memToReg), .regWrite(regWrite), .regDst(regDst),
        .stateOut(stateOut), .trap(trap)
    );

    wire [14:0] outs = {IRWrite, PCWrite, PCSrc, ALUSrc, ALUOp, extSel,
                        memRead, memWrite, memToReg, regWrite, regDst, trap};

    localparam logic [14:0] IRW  = 15'h4000;
    localparam logic [14:0] PCW  = 15'h2000;
    localparam logic [14:0] ASRC = 15'h0400;
    localparam logic [14:0] EXT  = 15'h0040;
    localparam logic [14:0] MRD  = 15'h0020;
    localparam logic [14:0] MWR  = 15'h0010;
    localparam logic [14:0] M2R  = 15'h0008;
    localparam logic [14:0] RW   = 15'h0004;
    localparam logic [14:0] RD   = 15'h0002;
    localparam logic [14:0] TRP  = 15'h0001;

    function automatic logic [14:0] pcs(input int v);
        return 15'(v) << 11;
    endfunction

    function automatic logic [14:0] aop(input int v);
        return 15'(v) << 7;
    endfunction

    typedef struct {
        logic [2:0]  st;
        logic [14:0] o;
        logic        rdy;
        logic [5:0]  op;
        logic [1:0]  md;
        logic        z;
        logic        n;
    } cyc_t;

    cyc_t plan_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    task automatic chk_state(input string tag, input logic [2:0] exp);
        n_cmp++;
        assert (stateOut === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d stateOut got %0d want %0d", tag, cyc_no, stateOut, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [14:0] exp);
        n_cmp++;
        assert (outs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d outputs got %h want %h", tag, cyc_no, outs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got %b want %b", tag, got, exp);
        end
    endtask

    // Appends one expected cycle; inputs that the block must ignore are random.
    task automatic add(input logic [2:0] st, input logic [14:0] o, input int rdy,
                       input int op, input int md, input int z, input int n);
        cyc_t c;
        c.st  = st;
        c.o   = o;
        c.rdy = (rdy < 0) ? 1'($urandom) : 1'(rdy);
        c.op  = (op < 0) ? 6'($urandom) : 6'(op);
        c.md  = (md < 0) ? 2'($urandom) : 2'(md);
        c.z   = (z < 0) ? 1'($urandom) : 1'(z);
        c.n   = (n < 0) ? 1'($urandom) : 1'(n);
        plan_q.push_back(c);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, from the ISA rules.
    task automatic plan_instr(input int op, input int md, input int fw, input int mw,
                              input int z, input int n);
        logic        is_alu, is_mem, is_br, is_jmp, legal, taken;
        logic [14:0] e;
        is_alu = (op <= 2);
        is_mem = (op == 3) || (op == 4);
        is_br  = (op >= 5) && (op <= 8);
        is_jmp = (op == 9);
        legal  = (op <= 9) && !(is_mem && md >= 2);

        for (int i = 0; i < fw; i++) add(3'd0, MRD, 0, -1, -1, -1, -1);
        add(3'd0, MRD | IRW | PCW | pcs(0), 1, -1, -1, -1, -1);
        add(3'd1, 15'h0, -1, op, md, -1, -1);

        if (!legal) begin
            add(3'd2, 15'h0, -1, -1, -1, z, n);
`ifdef ILLEGAL_OP_TRAP_EN
            for (int i = 0; i < 20; i++) add(3'd6, TRP, -1, -1, -1, -1, -1);
`endif
        end else if (is_alu) begin
            e = ASRC | aop(op) | ((op != 0) ? EXT : 15'h0);
            add(3'd2, e, -1, -1, -1, z, n);
            add(3'd4, e | RW, -1, -1, -1, -1, -1);
        end else if (is_mem) begin
            e = ASRC | aop(1) | EXT;
            add(3'd2, e, -1, -1, -1, z, n);
            for (int j = 0; j <= mw; j++)
                add(3'd3, e | ((op == 3) ? MRD : MWR), (j == mw) ? 1 : 0, -1, -1, -1, -1);
            if (op == 3) add(3'd4, e | RW | M2R, -1, -1, -1, -1, -1);
            if (md == 1) add(3'd5, e | RW | RD, -1, -1, -1, -1, -1);
        end else if (is_br) begin
            case (op)
                5:       taken = (z != 0);
                6:       taken = (z == 0);
                7:       taken = (z == 0) && (n == 0);
                default: taken = (n != 0);
            endcase
            e = aop(2) | EXT | (taken ? (PCW | pcs(1)) : 15'h0);
            add(3'd2, e, -1, -1, -1, z, n);
        end else if (is_jmp) begin
            add(3'd2, EXT | PCW | pcs(2), -1, -1, -1, z, n);
        end
    endtask

    task automatic run_plan(input string tag, input int limit);
        cyc_t c;
        int   k = 0;
        while (plan_q.size() > 0 && k < limit) begin
            c = plan_q.pop_front();
            @(negedge clk);
            memReady = c.rdy;
            opcode   = c.op;
            modeBits = c.md;
            aluZero  = c.z;
            aluNeg   = c.n;
            #1;
            cyc_no++;
            chk_state(tag, c.st);
            chk_outs(tag, c.o);
            k++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_state("reset_state", 3'd0);
        chk_outs("reset_outs", 15'h0);
        @(negedge clk);
        memReady = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk_state("release_state", 3'd0);
        chk_outs("release_outs", MRD);
    endtask

    initial begin
        int op, md;
        rst_n    = 1'b0;
        opcode   = 6'h0;
        modeBits = 2'b00;
        aluZero  = 1'b0;
        aluNeg   = 1'b0;
        memReady = 1'b1;
        #2;
        chk_state("por_state", 3'd0);
        chk_outs("por_outs", 15'h0);
        repeat (2) @(negedge clk);
        #1;
        chk_outs("por_ready_ignored", 15'h0);
        @(negedge clk);
        memReady = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk_state("por_release_state", 3'd0);
        chk_outs("por_release_outs", MRD);

        plan_instr(1, 0, 3, 0, 0, 0);   // ADDI with 3-cycle fetch stall
        run_plan("addi_stall", 1000);
        plan_instr(3, 1, 0, 2, 0, 0);   // LW post-inc, 2 wait cycles in MEM
        run_plan("lw_inc", 1000);
        plan_instr(8, 0, 0, 0, 0, 1);   // BLT taken
        run_plan("blt_taken", 1000);
        plan_instr(5, 0, 0, 0, 0, 0);   // BEQ not taken
        run_plan("beq_not", 1000);
        plan_instr(5, 0, 1, 0, 1, 0);
        plan_instr(6, 0, 0, 0, 1, 0);
        plan_instr(7, 0, 0, 0, 0, 0);
        plan_instr(7, 0, 0, 0, 0, 1);
        plan_instr(9, 2, 0, 0, 0, 0);
        plan_instr(0, 3, 0, 0, 1, 1);
        plan_instr(2, 0, 2, 0, 0, 0);
        plan_instr(4, 1, 0, 1, 0, 0);
        plan_instr(4, 0, 0, 0, 0, 0);
        plan_instr(3, 0, 1, 3, 0, 0);
        run_plan("directed", 1000);

        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 9);
            md = $urandom_range(0, 3);
            if (op == 3 || op == 4) md = $urandom_range(0, 1);
`ifndef ILLEGAL_OP_TRAP_EN
            if ($urandom_range(0, 9) == 0) op = $urandom_range(10, 63);
            if ((op == 3 || op == 4) && $urandom_range(0, 4) == 0) md = $urandom_range(2, 3);
`endif
            plan_instr(op, md, $urandom_range(0, 2), $urandom_range(0, 3),
                       $urandom_range(0, 1), $urandom_range(0, 1));
            run_plan("random", 1000);
        end

        // Reset while SW is waiting in MEM: request must drop at once.
        plan_instr(4, 0, 0, 10, 0, 0);
        run_plan("sw_pre_reset", 6);
        plan_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        chk_bit("midmem_memWrite", memWrite, 1'b0);
        chk_outs("midmem_outs", 15'h0);
        chk_state("midmem_state", 3'd0);
        @(negedge clk);
        memReady = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk_state("midmem_release_state", 3'd0);
        chk_bit("midmem_release_memRead", memRead, 1'b1);

        // Illegal LW mode, then illegal opcode 3F.
        plan_instr(3, 2, 0, 0, 0, 0);
        run_plan("illegal_mode", 1000);
`ifdef ILLEGAL_OP_TRAP_EN
        do_reset();
`endif
        plan_instr(63, 0, 0, 0, 0, 0);
        run_plan("illegal_3f", 1000);
`ifdef ILLEGAL_OP_TRAP_EN
        do_reset();
`endif
        plan_instr(1, 0, 0, 0, 0, 0);
        run_plan("after_illegal", 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
